// File: rtl/note_pkg.sv
// Shared note-word definitions for the recorder and the fixed-song players.
// A note word is {octave[1:0], code[2:0]}; code 0 is a rest.
package note_pkg;

   localparam int NOTE_W = 5;

   localparam logic [1:0] OCT_LOW  = 2'b00;
   localparam logic [1:0] OCT_MID  = 2'b01;
   localparam logic [1:0] OCT_HIGH = 2'b10;

   localparam logic [NOTE_W-1:0] REST = 5'b00_000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REC  = 2'd1,
      PLAY = 2'd2
   } state_t;

   // Tone-table index: code + 7*octave; 5 bits covers the largest stored value.
   function automatic logic [4:0] note_to_idx(input logic [NOTE_W-1:0] word);
      logic [4:0] oct_x7;
      oct_x7 = 5'(word[4:3]) * 5'd7;
      return 5'(word[2:0]) + oct_x7;
   endfunction

endpackage

// File: rtl/recorder_ram.sv
// Single-port DEPTH x 5 take memory with registered read data.
// Contents are never cleared; the take length gates what is reachable.
module recorder_ram
   import note_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [NOTE_W-1:0] din,
   output logic [NOTE_W-1:0] dout
);

   logic [NOTE_W-1:0] mem [DEPTH];
   logic [NOTE_W-1:0] dout_q;

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= din;
      dout_q <= mem[addr];
   end

   assign dout = dout_q;

endmodule

// File: rtl/note_recorder.sv
// Records live key notes one per tick and plays the take back one per tick.
// Playback path: tick -> RAM read -> output register, so note_valid lands 2 clk after tick.
module note_recorder
   import note_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              rec_start,
   input  logic              stop,
   input  logic              play_start,
   input  logic              loop_en,
   input  logic              key_valid,
   input  logic [NOTE_W-1:0] key_note,
   output logic [NOTE_W-1:0] note_out,
   output logic [4:0]        note_idx,
   output logic              note_valid,
   output logic              recording,
   output logic              playing,
   output logic              full,
   output logic [AW:0]       length
);

   state_t            state_q, state_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       length_q, length_d;
   logic              full_q, full_d;
   logic [NOTE_W-1:0] note_out_q, note_out_d;
   logic [4:0]        note_idx_q, note_idx_d;
   logic              note_valid_q, note_valid_d;
   logic              rd_pend_q, rd_pend_d;
   logic              done_q, done_d;

   logic              ram_we;
   logic [AW-1:0]     ram_addr;
   logic [NOTE_W-1:0] ram_din;
   logic [NOTE_W-1:0] ram_dout;

   recorder_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (ram_din),
      .dout (ram_dout)
   );

   // Released keys and the unused octave 11 are both captured as rests.
   assign ram_din  = (key_valid && key_note[4:3] != 2'b11) ? key_note : REST;
   assign ram_addr = (state_q == REC) ? wr_ptr_q : rd_ptr_q;

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      length_d     = length_q;
      full_d       = full_q;
      note_out_d   = note_out_q;
      note_idx_d   = note_idx_q;
      note_valid_d = 1'b0;
      rd_pend_d    = 1'b0;
      done_d       = done_q;
      ram_we       = 1'b0;

      unique case (state_q)
         IDLE: begin
            note_out_d = REST;
            note_idx_d = 5'd0;
            if (!stop) begin
               if (rec_start) begin
                  state_d  = REC;
                  wr_ptr_d = '0;
                  length_d = '0;
                  full_d   = 1'b0;
               end else if (play_start && length_q != '0) begin
                  state_d  = PLAY;
                  rd_ptr_d = '0;
                  done_d   = 1'b0;
               end
            end
         end
         REC: begin
            if (tick) begin
               ram_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               length_d = length_q + 1'b1;
               if (wr_ptr_q == AW'(DEPTH - 1)) begin
                  full_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            if (stop) state_d = IDLE;
         end
         PLAY: begin
            if (rd_pend_q) begin
               note_valid_d = 1'b1;
               note_out_d   = ram_dout;
               note_idx_d   = note_to_idx(ram_dout);
            end
            // Once the final slot is issued without looping, ticks wait out its output.
            if (tick && !done_q) begin
               rd_pend_d = 1'b1;
               if ({1'b0, rd_ptr_q} == length_q - 1'b1) begin
                  rd_ptr_d = '0;
                  done_d   = !loop_en;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
            if (note_valid_q && done_q) state_d = IDLE;
            if (stop) begin
               state_d = IDLE;
            end else if (rec_start) begin
               state_d  = REC;
               wr_ptr_d = '0;
               length_d = '0;
               full_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         length_q     <= '0;
         full_q       <= 1'b0;
         note_out_q   <= REST;
         note_idx_q   <= 5'd0;
         note_valid_q <= 1'b0;
         rd_pend_q    <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         length_q     <= length_d;
         full_q       <= full_d;
         note_out_q   <= note_out_d;
         note_idx_q   <= note_idx_d;
         note_valid_q <= note_valid_d;
         rd_pend_q    <= rd_pend_d;
         done_q       <= done_d;
      end
   end

   assign note_out   = note_out_q;
   assign note_idx   = note_idx_q;
   assign note_valid = note_valid_q;
   assign recording  = (state_q == REC);
   assign playing    = (state_q == PLAY);
   assign full       = full_q;
   assign length     = length_q;

endmodule
